// File: rtl/caliptra_prim_buf_scan_pkg.sv
// Shared types and constants for the dual-rail lane scan controller.
package caliptra_prim_buf_scan_pkg;

    localparam int ErrCntWidth = 8;
    localparam int StateWidth  = 6;

    // Sparse encoding: every pair of states differs in at least three bits,
    // so a single upset can never turn one legal state into another.
    typedef enum logic [StateWidth-1:0] {
        StIdle   = 6'b000000,
        StWait   = 6'b000111,
        StSettle = 6'b011001,
        StCheck  = 6'b101010,
        StDone   = 6'b110100
    } scan_state_e;

endpackage

// File: rtl/caliptra_prim_buf.sv
// Buffer cell. Its only job is to be a hierarchy boundary that synthesis
// keeps, so signals routed through it cannot be merged or folded.
module caliptra_prim_buf #(
    parameter int Width = 1
) (
    input  logic [Width-1:0] in_i,
    output logic [Width-1:0] out_o
);

    assign out_o = in_i;

endmodule

// File: rtl/caliptra_prim_buf_scan_ctrl.sv
// Sweeps a set of dual-rail hardened lanes one at a time, checking that the
// true and complement rails are exact complements. Sweeps run periodically
// while en_i is high or on demand via req_i; mismatches are recorded in a
// sticky error, a first-failing-lane capture and a saturating counter.
module caliptra_prim_buf_scan_ctrl
    import caliptra_prim_buf_scan_pkg::*;
#(
    parameter int NumLanes     = 4,
    parameter int Width        = 8,
    parameter int SettleCycles = 2,
    parameter int PeriodCycles = 16,
    localparam int LaneW       = (NumLanes > 1) ? $clog2(NumLanes) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic                      req_i,
    input  logic [NumLanes*Width-1:0] lane_i,
    input  logic [NumLanes*Width-1:0] lane_n_i,
    input  logic                      clr_i,
    output logic [LaneW-1:0]          lane_sel_o,
    output logic                      busy_o,
    output logic                      ack_o,
    output logic                      err_o,
    output logic [LaneW-1:0]          err_lane_o,
    output logic [ErrCntWidth-1:0]    err_cnt_o
);

    // One down-counter serves both the idle period and the settle time.
    localparam int CntMax = (PeriodCycles > SettleCycles) ? PeriodCycles : SettleCycles;
    localparam int CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0]        PeriodLoad = CntW'(PeriodCycles - 1);
    localparam logic [CntW-1:0]        SettleLoad = CntW'(SettleCycles - 1);
    localparam logic [LaneW-1:0]       LastLane   = LaneW'(NumLanes - 1);
    localparam logic [ErrCntWidth-1:0] ErrCntMax  = {ErrCntWidth{1'b1}};

    scan_state_e            state_q, state_d;
    logic [StateWidth-1:0]  state_raw;
    logic [LaneW-1:0]       lane_q, lane_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   pend_q, pend_d;
    logic                   srv_q, srv_d;
    logic                   err_q, err_d;
    logic [LaneW-1:0]       err_lane_q, err_lane_d;
    logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;

    logic                   pending, start, illegal, busy, done, do_check, mismatch;
    logic [Width-1:0]       sel_t, sel_n, sel_t_buf, sel_n_buf;
    logic                   err_base;
    logic [ErrCntWidth-1:0] cnt_base;

    // A request pulse counts immediately, even before it lands in pend_q.
    assign pending = pend_q | req_i;

    // The state is decoded through a buffer so the sparse encoding survives
    // synthesis and an illegal value stays detectable.
    caliptra_prim_buf #(.Width(StateWidth)) u_buf_state (
        .in_i  (state_q),
        .out_o (state_raw)
    );

    // Lane mux, then both rails through buffers so the XOR compare cannot
    // be simplified against the shared source.
    assign sel_t = lane_i[lane_q*Width +: Width];
    assign sel_n = lane_n_i[lane_q*Width +: Width];

    caliptra_prim_buf #(.Width(Width)) u_buf_true (
        .in_i  (sel_t),
        .out_o (sel_t_buf)
    );

    caliptra_prim_buf #(.Width(Width)) u_buf_comp (
        .in_i  (sel_n),
        .out_o (sel_n_buf)
    );

    assign mismatch = do_check && ((sel_t_buf ^ sel_n_buf) != {Width{1'b1}});

    // Next-state logic for the sweep sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        lane_d   = lane_q;
        cnt_d    = cnt_q;
        srv_d    = srv_q;
        start    = 1'b0;
        illegal  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        do_check = 1'b0;

        case (state_raw)
            StIdle: begin
                if (pending) begin
                    start = 1'b1;
                end else if (en_i) begin
                    state_d = StWait;
                    cnt_d   = PeriodLoad;
                end
            end
            StWait: begin
                if (pending) begin
                    start = 1'b1;
                end else if (!en_i) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    start = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StSettle: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StCheck: begin
                busy     = 1'b1;
                do_check = 1'b1;
                if (lane_q == LastLane) begin
                    state_d = StDone;
                end else begin
                    state_d = StSettle;
                    lane_d  = lane_q + LaneW'(1);
                    cnt_d   = SettleLoad;
                end
            end
            StDone: begin
                busy   = 1'b1;
                done   = 1'b1;
                lane_d = '0;
                if (pending) begin
                    start = 1'b1;
                end else if (en_i) begin
                    state_d = StWait;
                    cnt_d   = PeriodLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                illegal = 1'b1;
                state_d = StIdle;
                lane_d  = '0;
                cnt_d   = '0;
                srv_d   = 1'b0;
            end
        endcase

        // Every sweep begins at lane 0; remember whether a request started it.
        if (start) begin
            state_d = StSettle;
            lane_d  = '0;
            cnt_d   = SettleLoad;
            srv_d   = pending;
        end
    end

    // Pending request is consumed exactly when a sweep starts.
    assign pend_d = start ? 1'b0 : pending;

    // Error bookkeeping; a mismatch in the clearing cycle is applied on top
    // of the cleared values, so it wins.
    assign err_base = clr_i ? 1'b0 : err_q;
    assign cnt_base = clr_i ? '0 : err_cnt_q;

    always_comb begin
        err_d      = err_base;
        err_cnt_d  = cnt_base;
        err_lane_d = clr_i ? '0 : err_lane_q;
        if (mismatch) begin
            err_d     = 1'b1;
            err_cnt_d = (cnt_base == ErrCntMax) ? ErrCntMax : cnt_base + ErrCntWidth'(1);
            if (!err_base) begin
                err_lane_d = lane_q;
            end
        end
        if (illegal) begin
            err_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_ni) begin
            state_q    <= StIdle;
            lane_q     <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            srv_q      <= 1'b0;
            err_q      <= 1'b0;
            err_lane_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            srv_q      <= srv_d;
            err_q      <= err_d;
            err_lane_q <= err_lane_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign lane_sel_o = lane_q;
    assign busy_o     = busy;
    assign ack_o      = done & srv_q;
    assign err_o      = err_q;
    assign err_lane_o = err_lane_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_caliptra_prim_buf_scan_ctrl.sv
// Scoreboard bench for the lane scan controller: each requested sweep pushes
// its expected ack cycle and error snapshot; a monitor pops on every ack_o.
module tb_caliptra_prim_buf_scan_ctrl;

    localparam int NumLanes = 4;
    localparam int Width    = 8;

    logic                      clk_i = 1'b0;
    logic                      rst_ni, en_i, req_i, clr_i;
    logic [NumLanes*Width-1:0] lane_i, lane_n_i;
    logic [1:0]                lane_sel_o, err_lane_o;
    logic                      busy_o, ack_o, err_o;
    logic [7:0]                err_cnt_o;

    caliptra_prim_buf_scan_ctrl #(
        .NumLanes     (NumLanes),
        .Width        (Width),
        .SettleCycles (2),
        .PeriodCycles (16)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .req_i      (req_i),
        .lane_i     (lane_i),
        .lane_n_i   (lane_n_i),
        .clr_i      (clr_i),
        .lane_sel_o (lane_sel_o),
        .busy_o     (busy_o),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .err_lane_o (err_lane_o),
        .err_cnt_o  (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int         ack_cyc;
        logic       err;
        logic [1:0] lane;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack_o pulse must match the oldest outstanding request.
    always @(negedge clk_i) begin
        if (ack_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("ack_cycle", cyc, mon_e.ack_cyc);
                check("ack_err", {31'd0, err_o}, {31'd0, mon_e.err});
                check("ack_err_lane", {30'd0, err_lane_o}, {30'd0, mon_e.lane});
                check("ack_err_cnt", {24'd0, err_cnt_o}, {24'd0, mon_e.cnt});
            end
        end
    end

    task automatic push_exp(input int ack_cyc, input logic err, input logic [1:0] lane,
                            input logic [7:0] cnt);
        exp_t e;
        e.ack_cyc = ack_cyc;
        e.err     = err;
        e.lane    = lane;
        e.cnt     = cnt;
        sb_q.push_back(e);
    endtask

    // Lanes flagged in bad get a complement rail equal to the true rail.
    task automatic set_lanes(input logic [3:0] bad);
        logic [31:0] t;
        logic [31:0] n;
        t = 32'hA53C_0FF0;
        n = ~t;
        for (int k = 0; k < NumLanes; k++) begin
            if (bad[k]) n[k*Width +: Width] = t[k*Width +: Width];
        end
        lane_i   = t;
        lane_n_i = n;
    endtask

    // Request a sweep from IDLE; ack lands 13 cycles after the request cycle.
    task automatic sweep(input logic err, input logic [1:0] lane, input logic [7:0] cnt);
        @(negedge clk_i);
        push_exp(cyc + 13, err, lane, cnt);
        req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        if (sb_q.size() != 0) begin
            check({name, "_timeout"}, sb_q.size(), 32'd0);
            sb_q.delete();
        end
        @(negedge clk_i);
    endtask

    task automatic wait_busy(input logic level, input string name);
        int k;
        k = 0;
        while (busy_o !== level && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        if (busy_o !== level) check({name, "_timeout"}, {31'd0, busy_o}, {31'd0, level});
    endtask

    task automatic pulse_clr();
        @(negedge clk_i);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({name, "_ack"}, {31'd0, ack_o}, 32'd0);
        check({name, "_err"}, {31'd0, err_o}, 32'd0);
        check({name, "_err_lane"}, {30'd0, err_lane_o}, 32'd0);
        check({name, "_err_cnt"}, {24'd0, err_cnt_o}, 32'd0);
        check({name, "_lane_sel"}, {30'd0, lane_sel_o}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n;
        int c0;
        logic [7:0] exp_cnt;

        rst_ni = 1'b0;
        en_i   = 1'b0;
        req_i  = 1'b0;
        clr_i  = 1'b0;
        set_lanes(4'b0000);
        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // On-demand sweep, clean lanes: SETTLE/CHECK span 12 cycles, and the
        // DONE cycle carrying ack_o is busy as well, so busy_o lasts 13.
        sweep(1'b0, 2'd0, 8'd0);
        check("busy_after_req", {31'd0, busy_o}, 32'd1);
        busy_n = 1;
        repeat (19) begin
            @(negedge clk_i);
            if (busy_o) busy_n++;
        end
        check("busy_cycles", busy_n, 32'd13);
        wait_drain("clean");

        // Lane 2 rails equal: one mismatch per sweep, lane 2 captured.
        set_lanes(4'b0100);
        sweep(1'b1, 2'd2, 8'd1);
        wait_drain("lane2_a");
        sweep(1'b1, 2'd2, 8'd2);
        wait_drain("lane2_b");

        // Clear, then lanes 1 and 3 bad: first failing lane is 1, +2 per sweep
        // until the counter saturates at 255.
        pulse_clr();
        check("clr_err", {31'd0, err_o}, 32'd0);
        check("clr_cnt", {24'd0, err_cnt_o}, 32'd0);
        check("clr_lane", {30'd0, err_lane_o}, 32'd0);
        set_lanes(4'b1010);
        exp_cnt = 8'd0;
        for (int i = 0; i < 130; i++) begin
            exp_cnt = (exp_cnt > 8'd253) ? 8'd255 : exp_cnt + 8'd2;
            sweep(1'b1, 2'd1, exp_cnt);
            wait_drain("sat");
        end
        check("sat_cnt", {24'd0, err_cnt_o}, 32'd255);

        // clr_i lands on the lane 0 CHECK cycle with lane 0 bad: the
        // mismatch wins over the clear.
        set_lanes(4'b0001);
        sweep(1'b1, 2'd0, 8'd1);
        @(negedge clk_i);
        @(negedge clk_i);
        check("clr_check_lane_sel", {30'd0, lane_sel_o}, 32'd0);
        check("clr_check_busy", {31'd0, busy_o}, 32'd1);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        wait_drain("clr_mismatch");

        // Reset during lane 2 SETTLE with a second request pending: the sweep
        // and the pending request are both discarded, no ack_o follows.
        set_lanes(4'b0000);
        @(negedge clk_i);
        req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("pre_reset_lane_sel", {30'd0, lane_sel_o}, 32'd2);
        check("pre_reset_busy", {31'd0, busy_o}, 32'd1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check_all_zero("mid_reset");
        rst_ni = 1'b1;
        repeat (40) @(negedge clk_i);
        check("post_reset_busy", {31'd0, busy_o}, 32'd0);
        check("post_reset_lane_sel", {30'd0, lane_sel_o}, 32'd0);

        // Periodic sweeps with lane 2 bad: one count per sweep, no ack_o.
        set_lanes(4'b0100);
        @(negedge clk_i);
        en_i = 1'b1;
        wait_busy(1'b1, "per1_start");
        wait_busy(1'b0, "per1_end");
        check("per1_err", {31'd0, err_o}, 32'd1);
        check("per1_lane", {30'd0, err_lane_o}, 32'd2);
        check("per1_cnt", {24'd0, err_cnt_o}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            wait_busy(1'b1, "per_start");
            wait_busy(1'b0, "per_end");
        end
        check("per3_cnt", {24'd0, err_cnt_o}, 32'd3);

        // Now in WAIT: a request preempts the period, and a second request
        // during that sweep is served by a sweep right after its DONE.
        set_lanes(4'b0000);
        pulse_clr();
        check("wait_clr_err", {31'd0, err_o}, 32'd0);
        repeat (2) @(negedge clk_i);
        @(negedge clk_i);
        c0 = cyc;
        push_exp(c0 + 13, 1'b0, 2'd0, 8'd0);
        req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
        check("wait_req_busy", {31'd0, busy_o}, 32'd1);
        check("wait_req_lane_sel", {30'd0, lane_sel_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        push_exp(c0 + 26, 1'b0, 2'd0, 8'd0);
        req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
        wait_drain("double_req");
        en_i = 1'b0;
        repeat (5) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
